// File: rtl/regfile_wport_arbiter.sv
// Write-port sequencer for the register file: round-robin ALU/load writeback
// arbitration plus a zeroing sweep of r0..r14 after reset or on clear_req.
module regfile_wport_arbiter #(
    parameter int DW   = 32,
    parameter int AW   = 4,
    parameter int NREG = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          we3,
    output logic [AW-1:0] wa3,
    output logic [DW-1:0] wd3,
    output logic          busy,
    output logic          err_r15
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic          LG_ALU   = 1'b0;
    localparam logic          LG_LD    = 1'b1;
    localparam logic [AW-1:0] CNT_LAST = AW'(NREG - 1);
    localparam logic [AW-1:0] ADDR_PC  = AW'(NREG);

    state_t        state, state_next;
    logic [AW-1:0] cnt, cnt_next;
    logic          lg, lg_next;
    logic          grant;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        lg_next    = lg;
        alu_ready  = 1'b0;
        ld_ready   = 1'b0;
        case (state)
            INIT: begin
                if (clear_req) begin
                    cnt_next = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + AW'(1);
                end
            end
            RUN: begin
                if (clear_req) begin
                    state_next = INIT;
                    cnt_next   = '0;
                end else begin
                    // On conflict the source that did not win last time goes first
                    alu_ready = alu_valid && (!ld_valid || lg == LG_LD);
                    ld_ready  = ld_valid && !alu_ready;
                    if (alu_ready)     lg_next = LG_ALU;
                    else if (ld_ready) lg_next = LG_LD;
                end
            end
            default: state_next = INIT;
        endcase
    end

    assign grant  = alu_ready || ld_ready;
    assign w_addr = alu_ready ? alu_addr : ld_addr;
    assign w_data = alu_ready ? alu_data : ld_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt   <= '0;
            lg    <= LG_LD;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            lg    <= lg_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3     <= 1'b0;
            wa3     <= '0;
            wd3     <= '0;
            busy    <= 1'b1;
            err_r15 <= 1'b0;
        end else begin
            busy <= (state_next == INIT);
            if (state == INIT) begin
                we3     <= 1'b1;
                wa3     <= cnt;
                wd3     <= '0;
                err_r15 <= 1'b0;
            end else if (grant) begin
                // r15 is the PC: the request is consumed but never written
                wa3     <= w_addr;
                wd3     <= w_data;
                we3     <= (w_addr != ADDR_PC);
                err_r15 <= (w_addr == ADDR_PC);
            end else begin
                we3     <= 1'b0;
                err_r15 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Randomized bench for regfile_wport_arbiter against a queue-based model of
// the sweep and a priority-token model of the round-robin arbitration.
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        alu_valid, ld_valid;
    logic [3:0]  alu_addr, ld_addr;
    logic [31:0] alu_data, ld_data;
    logic        alu_ready, ld_ready;
    logic        we3, busy, err_r15;
    logic [3:0]  wa3;
    logic [31:0] wd3;

    regfile_wport_arbiter #(.DW(32), .AW(4), .NREG(15)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy), .err_r15(err_r15)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: outstanding sweep writes as a queue of addresses; priority token
    int          sweep_q[$];
    bit          prio_alu;
    bit          e_we, e_busy, e_err;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;

    task automatic refill();
        sweep_q = {};
        for (int i = 0; i < 15; i++) sweep_q.push_back(i);
    endtask

    task automatic model_reset();
        refill();
        prio_alu = 1'b1;
        e_we = 0; e_wa = '0; e_wd = '0; e_busy = 1; e_err = 0;
    endtask

    task automatic exp_grant(output bit ga, output bit gl);
        ga = 0; gl = 0;
        if (sweep_q.size() == 0 && !clear_req) begin
            ga = alu_valid && (!ld_valid || prio_alu);
            gl = ld_valid && !ga;
        end
    endtask

    task automatic model_edge(input bit ga, input bit gl);
        logic [3:0] a;
        if (sweep_q.size() > 0) begin
            e_wa  = 4'(sweep_q.pop_front());
            e_we  = 1; e_wd = '0; e_err = 0;
            if (clear_req) refill();
            e_busy = (sweep_q.size() > 0);
        end else if (clear_req) begin
            e_we = 0; e_err = 0; e_busy = 1;
            refill();
        end else if (ga || gl) begin
            a     = ga ? alu_addr : ld_addr;
            e_wa  = a;
            e_wd  = ga ? alu_data : ld_data;
            e_we  = (a != 4'd15);
            e_err = (a == 4'd15);
            prio_alu = gl;
        end else begin
            e_we = 0; e_err = 0;
        end
    endtask

    bit last_ga, last_gl;

    // One clock: check readies mid-cycle, advance model at the edge, check outputs after it
    task automatic cycle();
        bit ga, gl;
        @(negedge clk);
        exp_grant(ga, gl);
        chk("alu_ready", 64'(alu_ready), 64'(ga));
        chk("ld_ready", 64'(ld_ready), 64'(gl));
        @(posedge clk);
        model_edge(ga, gl);
        #1;
        chk("we3", 64'(we3), 64'(e_we));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("err_r15", 64'(err_r15), 64'(e_err));
        if (e_we || e_err) begin
            chk("wa3", 64'(wa3), 64'(e_wa));
            chk("wd3", 64'(wd3), 64'(e_wd));
        end
        last_ga = ga; last_gl = gl;
    endtask

    task automatic drive_random();
        if (!alu_valid || last_ga) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_addr  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            alu_data  = $urandom;
        end
        if (!ld_valid || last_gl) begin
            ld_valid = ($urandom_range(0, 99) < 60);
            ld_addr  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            ld_data  = $urandom;
        end
        clear_req = ($urandom_range(0, 99) < 2);
    endtask

    // Called just after a rising edge; reset asserts between edges
    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "_we3"}, 64'(we3), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(1));
        chk({tag, "_err"}, 64'(err_r15), 64'(0));
        chk({tag, "_rdy"}, 64'({alu_ready, ld_ready}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        last_ga = 0; last_gl = 0;
    endtask

    initial begin
        reset = 1'b0; clear_req = 0;
        alu_valid = 0; alu_addr = '0; alu_data = '0;
        ld_valid = 0; ld_addr = '0; ld_data = '0;
        last_ga = 0; last_gl = 0;
        model_reset();
        #1;
        chk("rst_wa3", 64'(wa3), 64'(0));
        chk("rst_wd3", 64'(wd3), 64'(0));
        @(posedge clk); #1;
        apply_reset("rst0");

        // Sweep with no requests, then idle
        for (int i = 0; i < 17; i++) cycle();

        // Single ALU write
        alu_valid = 1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_wa3", 64'(wa3), 64'(3));
        chk("alu_wd3", 64'(wd3), 64'hDEADBEEF);
        alu_valid = 0;
        cycle();

        // Both continuously valid: grants must alternate
        alu_valid = 1; alu_addr = 4'd1; alu_data = 32'h11;
        ld_valid  = 1; ld_addr  = 4'd2; ld_data  = 32'h22;
        cycle();
        for (int i = 0; i < 3; i++) begin
            logic [3:0] prev;
            prev = wa3;
            cycle();
            chk("alt_wa3", 64'(wa3), 64'(prev == 4'd1 ? 4'd2 : 4'd1));
        end
        alu_valid = 0; ld_valid = 0;
        cycle();

        // Load to r15 is consumed and flagged
        ld_valid = 1; ld_addr = 4'd15; ld_data = 32'hCAFE0001;
        cycle();
        ld_valid = 0;
        chk("r15_err", 64'(err_r15), 64'(1));
        chk("r15_we3", 64'(we3), 64'(0));
        cycle();

        // clear_req in RUN blocks a pending ALU request until the sweep ends
        alu_valid = 1; alu_addr = 4'd9; alu_data = 32'h12345678;
        clear_req = 1;
        cycle();
        clear_req = 0;
        for (int i = 0; i < 15; i++) cycle();
        cycle();
        chk("post_clear_grant", 64'(last_ga), 64'(1));
        alu_valid = 0;
        cycle();

        // Reset in the middle of a sweep
        @(posedge clk); #1;
        apply_reset("rst1");
        for (int i = 0; i < 7; i++) cycle();
        apply_reset("rst_mid");
        cycle();
        chk("restart_wa3", 64'(wa3), 64'(0));

        // Randomized traffic with occasional resets and clears
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            if ($urandom_range(0, 999) < 3) apply_reset("rst_rand");
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
